// File: rtl/mem_write_buffer.sv
// Store buffer between a cache controller and an SRAM controller: queues stores, drains them, and serves line-fill reads.
// Optional macro WBUF_READ_BYPASS_EN lets a read overtake queued stores whose 64-bit line does not match.
module mem_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        ready,
    output logic [63:0] read_data,
    output logic        sram_write_en,
    output logic        sram_read_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [63:0] sram_read_data,
    input  logic        sram_ready,
    output logic        full,
    output logic        empty
);

    // state | meaning
    // IDLE  | choose between an eligible read and draining the head store
    // WRITE | head store presented to SRAM, waiting for sram_ready
    // READ  | line fill presented to SRAM, waiting for sram_ready
    // DONE  | fill data registered, ready pulsed to the requester
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    state_t          r_state;
    logic [31:0]     r_addr_q [DEPTH];
    logic [31:0]     r_data_q [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_wen;
    logic            r_ren;
    logic [31:0]     r_sram_addr;
    logic [31:0]     r_sram_wdata;
    logic [63:0]     r_read_data;

    logic            w_push;
    logic            w_pop;
    logic            w_rd_ok;

    assign full            = (r_count == CW'(DEPTH));
    assign empty           = (r_count == '0);
    assign w_push          = wr_req & ~rd_req & ~full;
    assign w_pop           = (r_state == WRITE) & sram_ready;
    assign ready           = rst & (rd_req ? (r_state == DONE) : (wr_req & ~full));
    assign sram_write_en   = r_wen;
    assign sram_read_en    = r_ren;
    assign sram_address    = r_sram_addr;
    assign sram_write_data = r_sram_wdata;
    assign read_data       = r_read_data;

`ifdef WBUF_READ_BYPASS_EN
    logic w_line_hit;

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        w_line_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(PW'(i) - r_rptr) < r_count) && (r_addr_q[i][31:3] == address[31:3])) begin
                w_line_hit = 1'b1;
            end
        end
    end

    assign w_rd_ok = ~w_line_hit;
`else
    assign w_rd_ok = empty;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_q[r_wptr] <= address;
            r_data_q[r_wptr] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_wen        <= 1'b0;
            r_ren        <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
            r_read_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (rd_req && w_rd_ok) begin
                        r_state     <= READ;
                        r_ren       <= 1'b1;
                        r_sram_addr <= address;
                    end else if (!empty) begin
                        r_state      <= WRITE;
                        r_wen        <= 1'b1;
                        r_sram_addr  <= r_addr_q[r_rptr];
                        r_sram_wdata <= r_data_q[r_rptr];
                    end
                end
                WRITE: begin
                    if (sram_ready) begin
                        r_state <= IDLE;
                        r_wen   <= 1'b0;
                    end
                end
                READ: begin
                    if (sram_ready) begin
                        r_state     <= DONE;
                        r_ren       <= 1'b0;
                        r_read_data <= sram_read_data;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_write_buffer.md
MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, 4, number of store entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port wr_req  input  1  store request from cache controller, held until ready.
REQ-005 SHALL have port rd_req  input  1  line-fill read request, held until ready.
REQ-006 SHALL have port address  input  32  byte address of request.
REQ-007 SHALL have port write_data  input  32  store data.
REQ-008 SHALL have port ready  output  1  request accepted/completed; pipeline freezes while low.
REQ-009 SHALL have port read_data  output  64  fill data returned for rd_req.
REQ-010 SHALL have port sram_write_en / sram_read_en  output  1 each  commands to SRAM controller.
REQ-011 SHALL have port sram_address  output  32  and sram_write_data  output  32  SRAM command operands.
REQ-012 SHALL have port sram_read_data  input  64  and sram_ready  input  1  SRAM controller results.
REQ-013 SHALL have port full / empty  output  1 each  occupancy status.

Function
REQ-014 SHALL hold a circular FIFO of DEPTH {address, data} entries with wrapping read/write pointers and a count 0..DEPTH.
REQ-015 SHALL drive ready=~full combinationally while wr_req=1, rd_req=0; on a clock edge with wr_req=1 and ~full, SHALL enqueue the entry.
REQ-016 SHALL NOT enqueue when full, even if a pop occurs in the same cycle; simultaneous push and pop when not full SHALL leave count unchanged.
REQ-017 SHALL implement FSM states IDLE, WRITE, READ, DONE.
REQ-018 In IDLE, when not empty and no eligible read, SHALL go to WRITE, driving sram_write_en=1 with head address/data held stable.
REQ-019 In WRITE, on sram_ready=1 SHALL pop the head, drop sram_write_en the next cycle, and return to IDLE.
REQ-020 In IDLE, when rd_req=1 and the read is eligible (REQ-030/031), SHALL go to READ, driving sram_read_en=1 and sram_address=address.
REQ-021 In READ, on sram_ready=1 SHALL register sram_read_data into read_data and go to DONE.
REQ-022 In DONE, SHALL assert ready=1 for exactly one cycle, then return to IDLE.
REQ-023 Read latency from SRAM completion to ready SHALL be one cycle; read_data SHALL stay stable until the next read completes.
REQ-024 A write in progress (WRITE) SHALL never be aborted by a new rd_req.
REQ-025 wr_req and rd_req both high SHALL be treated as rd_req only; wr_req with rd_req=0 SHALL never wait on the FSM.
REQ-026 full SHALL equal (count==DEPTH); empty SHALL equal (count==0); both SHALL be registered-count derived, glitch-free.

Reset
REQ-027 rst=0 SHALL asynchronously clear pointers, count, FSM to IDLE, sram_write_en=0, sram_read_en=0, read_data=0, ready=0, full=0, empty=1.
REQ-028 Reset mid-operation SHALL discard all buffered stores and any outstanding SRAM command without completion.
REQ-029 After rst rises, the first request SHALL be accepted no earlier than the next rising edge.

Configuration
REQ-030 With macro WBUF_READ_BYPASS_EN defined, a rd_req SHALL be eligible in IDLE when no valid entry matches address[31:3] (64-bit line compare), bypassing queued stores.
REQ-031 Without WBUF_READ_BYPASS_EN, a rd_req SHALL be eligible only when empty=1; queued stores SHALL drain first.
REQ-032 With the macro defined and a line match, SHALL drain until no matching entry remains, then issue the read.

Verification
REQ-033 Reset, then wr_req with address=0x100, data=0xA5A5 -> ready=1 same cycle, empty=0 next cycle, sram_write_en=1 with sram_address=0x100 by the following cycle.
REQ-034 Five back-to-back stores, DEPTH=4, sram_ready held 0 -> ready=0 and full=1 on the fifth; the fifth is accepted the cycle after the first sram_ready pulse.
REQ-035 Buffer holds store to 0x200, rd_req to 0x400 -> with macro: read issued before the store, ready pulses one cycle after sram_ready; without macro: store completes first.
REQ-036 With macro, buffer holds store to 0x204, rd_req to 0x200 -> store drains, then read returns sram_read_data=0x1122334455667788 on read_data.
REQ-037 rst pulsed low during WRITE with 3 entries -> sram_write_en=0 immediately, empty=1, no pop-dependent outputs afterward.
